// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared widths, ID/EX control-word field map and NOP word
package id_ex_pkg;

    localparam int CTRL_W = 17;
    localparam int ADDR_W = 32;

    localparam int SO_MSB     = 16;
    localparam int SO_LSB     = 14;
    localparam int ALU_MSB    = 13;
    localparam int ALU_LSB    = 10;
    localparam int LOAD_BIT   = 9;
    localparam int RF_EN_BIT  = 8;
    localparam int B_BIT      = 7;
    localparam int TA_BIT     = 6;
    localparam int SIZE_MSB   = 5;
    localparam int SIZE_LSB   = 4;
    localparam int RW_BIT     = 3;
    localparam int SE_BIT     = 2;
    localparam int HI_BIT     = 1;
    localparam int LO_BIT     = 0;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // All-zero word: no RF write, no memory access, no HI/LO write.
    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_ctrl_path_if.sv
// rtl/id_ex_ctrl_path_if.sv - PC/control bundle between ID-stage drivers and the ID/EX path (optional EX_FLUSH_EN)
interface id_ex_ctrl_path_if #(
    parameter int CTRL_W = 17,
    parameter int ADDR_W = 32
);

    logic [ADDR_W-1:0] adder_in;
    logic [ADDR_W-1:0] adder_out;
    logic [CTRL_W-1:0] control_signals;
    logic              S;
    logic [CTRL_W-1:0] mux_control_signals;
    logic [CTRL_W-1:0] control_signals_out;
    logic [2:0]        ex_so;
    logic [3:0]        ex_alu_op;
    logic              ex_load_instr;
    logic              ex_rf_enable;
    logic              ex_b_instr;
    logic              ex_ta_instr;
    logic [1:0]        ex_mem_size;
    logic              ex_mem_rw;
    logic              ex_mem_se;
    logic              ex_enable_hi;
    logic              ex_enable_lo;
    logic              ex_mem_enable;
`ifdef EX_FLUSH_EN
    logic              ex_flush;
`endif

    modport master (
`ifdef EX_FLUSH_EN
        output ex_flush,
`endif
        output adder_in, control_signals, S,
        input  adder_out, mux_control_signals, control_signals_out,
        input  ex_so, ex_alu_op, ex_load_instr, ex_rf_enable, ex_b_instr,
        input  ex_ta_instr, ex_mem_size, ex_mem_rw, ex_mem_se,
        input  ex_enable_hi, ex_enable_lo, ex_mem_enable
    );

    modport slave (
`ifdef EX_FLUSH_EN
        input  ex_flush,
`endif
        input  adder_in, control_signals, S,
        output adder_out, mux_control_signals, control_signals_out,
        output ex_so, ex_alu_op, ex_load_instr, ex_rf_enable, ex_b_instr,
        output ex_ta_instr, ex_mem_size, ex_mem_rw, ex_mem_se,
        output ex_enable_hi, ex_enable_lo, ex_mem_enable
    );

endinterface

// File: rtl/pc_incrementer.sv
// rtl/pc_incrementer.sv - combinational PC + 4, carry out discarded
module pc_incrementer #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] pc_next_o
);

    assign pc_next_o = pc_i + WIDTH'(4);

endmodule

// File: rtl/id_ex_ctrl_path.sv
// rtl/id_ex_ctrl_path.sv - PC+4 adder, NOP-injecting control mux and ID/EX register (optional EX_FLUSH_EN)
module id_ex_ctrl_path #(
    parameter int CTRL_W = 17,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    id_ex_ctrl_path_if.slave    bus
);

    import id_ex_pkg::*;

    logic [CTRL_W-1:0] mux_word;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;

    pc_incrementer #(
        .WIDTH (ADDR_W)
    ) u_pc_inc (
        .pc_i      (bus.adder_in),
        .pc_next_o (bus.adder_out)
    );

    // Compare against 0 so an unknown select falls to the bubble, never pass-through.
    always_comb begin
        mux_word = CTRL_NOP;
        if (bus.S == 1'b0) begin
            mux_word = bus.control_signals;
        end
    end

    assign bus.mux_control_signals = mux_word;

    always_comb begin
        ctrl_d = mux_word;
`ifdef EX_FLUSH_EN
        if (bus.ex_flush) begin
            ctrl_d = CTRL_NOP;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.control_signals_out = ctrl_q;
    assign bus.ex_so         = ctrl_q[SO_MSB:SO_LSB];
    assign bus.ex_alu_op     = ctrl_q[ALU_MSB:ALU_LSB];
    assign bus.ex_load_instr = ctrl_q[LOAD_BIT];
    assign bus.ex_rf_enable  = ctrl_q[RF_EN_BIT];
    assign bus.ex_b_instr    = ctrl_q[B_BIT];
    assign bus.ex_ta_instr   = ctrl_q[TA_BIT];
    assign bus.ex_mem_size   = ctrl_q[SIZE_MSB:SIZE_LSB];
    assign bus.ex_mem_rw     = ctrl_q[RW_BIT];
    assign bus.ex_mem_se     = ctrl_q[SE_BIT];
    assign bus.ex_enable_hi  = ctrl_q[HI_BIT];
    assign bus.ex_enable_lo  = ctrl_q[LO_BIT];
    assign bus.ex_mem_enable = ctrl_q[LOAD_BIT] | ctrl_q[RW_BIT];

endmodule

// File: tb/tb_id_ex_ctrl_path.sv
// tb/tb_id_ex_ctrl_path.sv - directed self-checking bench for id_ex_ctrl_path (optional EX_FLUSH_EN)
module tb_id_ex_ctrl_path;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    id_ex_ctrl_path_if #(.CTRL_W(17), .ADDR_W(32)) bif ();

    id_ex_ctrl_path #(.CTRL_W(17), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0;
        bif.adder_in        = 32'h0;
        bif.control_signals = 17'h0;
        bif.S               = 1'b0;
`ifdef EX_FLUSH_EN
        bif.ex_flush        = 1'b0;
`endif
        step();
        check_eq("reset_out",     32'(bif.control_signals_out), 32'h0);
        check_eq("reset_mem_en",  32'(bif.ex_mem_enable),       32'h0);

        bif.adder_in = 32'h0000_0000; #1;
        check_eq("add_0",    bif.adder_out, 32'h0000_0004);
        bif.adder_in = 32'h0000_0010; #1;
        check_eq("add_10",   bif.adder_out, 32'h0000_0014);
        bif.adder_in = 32'hFFFF_FFFC; #1;
        check_eq("add_wrap", bif.adder_out, 32'h0000_0000);

        bif.control_signals = 17'h1ABCD; bif.S = 1'b0; #1;
        check_eq("mux_pass", 32'(bif.mux_control_signals), 32'h1ABCD);
        bif.S = 1'b1; #1;
        check_eq("mux_nop",  32'(bif.mux_control_signals), 32'h0);

        // Release reset between edges, then present the all-ones word.
        step();
        reset = 1'b1;
        bif.S = 1'b0;
        bif.control_signals = 17'h1FFFF; #1;
        check_eq("pipe_before", 32'(bif.control_signals_out), 32'h0);
        step();
        check_eq("pipe_after",  32'(bif.control_signals_out), 32'h1FFFF);
        check_eq("pipe_alu",    32'(bif.ex_alu_op),           32'hF);
        check_eq("pipe_size",   32'(bif.ex_mem_size),         32'h3);
        check_eq("pipe_mem_en", 32'(bif.ex_mem_enable),       32'h1);

        bif.control_signals = 17'b101_0011_1_1_0_0_10_0_1_0_1;
        step();
        check_eq("dec_so",    32'(bif.ex_so),         32'h5);
        check_eq("dec_alu",   32'(bif.ex_alu_op),     32'h3);
        check_eq("dec_load",  32'(bif.ex_load_instr), 32'h1);
        check_eq("dec_rf",    32'(bif.ex_rf_enable),  32'h1);
        check_eq("dec_b",     32'(bif.ex_b_instr),    32'h0);
        check_eq("dec_ta",    32'(bif.ex_ta_instr),   32'h0);
        check_eq("dec_size",  32'(bif.ex_mem_size),   32'h2);
        check_eq("dec_rw",    32'(bif.ex_mem_rw),     32'h0);
        check_eq("dec_se",    32'(bif.ex_mem_se),     32'h1);
        check_eq("dec_hi",    32'(bif.ex_enable_hi),  32'h0);
        check_eq("dec_lo",    32'(bif.ex_enable_lo),  32'h1);
        check_eq("dec_memen", 32'(bif.ex_mem_enable), 32'h1);

        // Store-only word: mem_enable must come from mem_rw alone.
        bif.control_signals = 17'h00008;
        step();
        check_eq("store_rw",    32'(bif.ex_mem_rw),     32'h1);
        check_eq("store_memen", 32'(bif.ex_mem_enable), 32'h1);

        bif.control_signals = 17'h1FFFF;
        step();
        #2 reset = 1'b0;
        #1;
        check_eq("arst_out", 32'(bif.control_signals_out), 32'h0);
        check_eq("arst_so",  32'(bif.ex_so),               32'h0);
        step();
        check_eq("arst_hold", 32'(bif.control_signals_out), 32'h0);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_rel_noedge", 32'(bif.control_signals_out), 32'h0);
        step();
        check_eq("arst_reload", 32'(bif.control_signals_out), 32'h1FFFF);

        bif.S = 1'b1; #1;
        check_eq("bub_mux",  32'(bif.mux_control_signals), 32'h0);
        check_eq("bub_held", 32'(bif.control_signals_out), 32'h1FFFF);
        step();
        check_eq("bub_edge1", 32'(bif.control_signals_out), 32'h0);
        step();
        check_eq("bub_edge2", 32'(bif.control_signals_out), 32'h0);
        check_eq("bub_rf",    32'(bif.ex_rf_enable),        32'h0);
        bif.S = 1'b0;
        bif.control_signals = 17'h0ACE1;
        step();
        check_eq("bub_resume", 32'(bif.control_signals_out), 32'h0ACE1);

`ifdef EX_FLUSH_EN
        bif.control_signals = 17'h1FFFF;
        step();
        check_eq("fl_pre", 32'(bif.control_signals_out), 32'h1FFFF);
        bif.ex_flush = 1'b1;
        step();
        check_eq("fl_zero", 32'(bif.control_signals_out), 32'h0);
        bif.ex_flush = 1'b0;
        step();
        check_eq("fl_resume", 32'(bif.control_signals_out), 32'h1FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
